// File: rtl/csr_ctrl.sv
// Initiator for the machine-mode CSR file: serialises RMW, trap-entry and MRET
// accesses onto the single CSR port and returns the old value or a PC redirect.
module csr_ctrl #(
   parameter int unsigned MIE_BIT  = 3,
   parameter int unsigned MPIE_BIT = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_operand,
   input  logic [31:0] req_cause,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_redirect,
   output logic [31:0] rsp_pc,
   output logic        rsp_illegal,
   output logic        csr_write_en,
   output logic [11:0] csr_addr,
   output logic [31:0] csr_din,
   input  logic [31:0] csr_dout
);

   localparam logic [2:0]  OP_RW   = 3'd0;
   localparam logic [2:0]  OP_RS   = 3'd1;
   localparam logic [2:0]  OP_RC   = 3'd2;
   localparam logic [2:0]  OP_TRAP = 3'd4;
   localparam logic [2:0]  OP_MRET = 3'd5;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   typedef enum logic [3:0] {
      IDLE, RMW_RD, RMW_WR,
      TRAP_EPC, TRAP_CAUSE, TRAP_ST_RD, TRAP_ST_WR, TRAP_VEC,
      MRET_ST_RD, MRET_ST_WR, MRET_EPC,
      RESP
   } state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [11:0] addr_q;
   logic [31:0] operand_q;
   logic [31:0] cause_q;
   logic [31:0] old_q;
   logic        write_q;

   logic [31:0] rmw_new;
   logic [31:0] trap_st;
   logic [31:0] mret_st;
   logic        rmw_wr;
   logic        rmw_ro;

   // New CSR values derived from the value the CSR file is presenting this cycle
   always_comb begin
      rmw_new = req_operand_sel(op_q, csr_dout, operand_q);
      rmw_wr  = (op_q == OP_RW) || (operand_q != 32'h0);
      rmw_ro  = (addr_q[11:10] == 2'b11);
      trap_st = csr_dout;
      trap_st[MPIE_BIT] = csr_dout[MIE_BIT];
      trap_st[MIE_BIT]  = 1'b0;
      mret_st = csr_dout;
      mret_st[MIE_BIT]  = csr_dout[MPIE_BIT];
      mret_st[MPIE_BIT] = 1'b1;
   end

   function automatic logic [31:0] req_operand_sel(input logic [2:0] op,
                                                   input logic [31:0] old,
                                                   input logic [31:0] operand);
      case (op)
         OP_RS:   return old | operand;
         OP_RC:   return old & ~operand;
         default: return operand;
      endcase
   endfunction

   // A write scheduled for the current cycle is dropped as soon as reset is raised
   assign csr_write_en = write_q & ~rst;

   // Outputs are registered for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'h0;
         rsp_redirect <= 1'b0;
         rsp_pc       <= 32'h0;
         rsp_illegal  <= 1'b0;
         write_q      <= 1'b0;
         csr_addr     <= 12'h0;
         csr_din      <= 32'h0;
         op_q         <= 3'h0;
         addr_q       <= 12'h0;
         operand_q    <= 32'h0;
         cause_q      <= 32'h0;
         old_q        <= 32'h0;
      end else begin
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'h0;
         rsp_redirect <= 1'b0;
         rsp_pc       <= 32'h0;
         rsp_illegal  <= 1'b0;
         write_q      <= 1'b0;
         csr_addr     <= 12'h0;
         csr_din      <= 32'h0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  addr_q    <= req_addr;
                  operand_q <= req_operand;
                  cause_q   <= req_cause;
                  case (req_op)
                     OP_RW, OP_RS, OP_RC: begin
                        state    <= RMW_RD;
                        csr_addr <= req_addr;
                     end
                     OP_TRAP: begin
                        state    <= TRAP_EPC;
                        write_q  <= 1'b1;
                        csr_addr <= ADDR_MEPC;
                        csr_din  <= req_pc & ~32'h3;
                     end
                     OP_MRET: begin
                        state    <= MRET_ST_RD;
                        csr_addr <= ADDR_MSTATUS;
                     end
                     default: begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_illegal <= 1'b1;
                     end
                  endcase
               end else begin
                  req_ready <= 1'b1;
               end
            end
            RMW_RD: begin
               state    <= RMW_WR;
               old_q    <= csr_dout;
               csr_addr <= addr_q;
               csr_din  <= rmw_new;
               write_q  <= rmw_wr && !rmw_ro;
            end
            RMW_WR: begin
               state       <= RESP;
               rsp_valid   <= 1'b1;
               rsp_rdata   <= old_q;
               rsp_illegal <= rmw_wr && rmw_ro;
            end
            TRAP_EPC: begin
               state    <= TRAP_CAUSE;
               write_q  <= 1'b1;
               csr_addr <= ADDR_MCAUSE;
               csr_din  <= cause_q;
            end
            TRAP_CAUSE: begin
               state    <= TRAP_ST_RD;
               csr_addr <= ADDR_MSTATUS;
            end
            TRAP_ST_RD: begin
               state    <= TRAP_ST_WR;
               write_q  <= 1'b1;
               csr_addr <= ADDR_MSTATUS;
               csr_din  <= trap_st;
            end
            TRAP_ST_WR: begin
               state    <= TRAP_VEC;
               csr_addr <= ADDR_MTVEC;
            end
            TRAP_VEC: begin
               state        <= RESP;
               rsp_valid    <= 1'b1;
               rsp_redirect <= 1'b1;
               rsp_pc       <= csr_dout & ~32'h3;
            end
            MRET_ST_RD: begin
               state    <= MRET_ST_WR;
               write_q  <= 1'b1;
               csr_addr <= ADDR_MSTATUS;
               csr_din  <= mret_st;
            end
            MRET_ST_WR: begin
               state    <= MRET_EPC;
               csr_addr <= ADDR_MEPC;
            end
            MRET_EPC: begin
               state        <= RESP;
               rsp_valid    <= 1'b1;
               rsp_redirect <= 1'b1;
               rsp_pc       <= csr_dout;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_ctrl.sv
// Bench for csr_ctrl: behavioural CSR file, response scoreboard and write log.
module tb_csr_ctrl;

   localparam logic [2:0] OP_RW   = 3'd0;
   localparam logic [2:0] OP_RS   = 3'd1;
   localparam logic [2:0] OP_RC   = 3'd2;
   localparam logic [2:0] OP_TRAP = 3'd4;
   localparam logic [2:0] OP_MRET = 3'd5;

   typedef struct packed {
      logic [7:0]  lat;
      logic [31:0] rdata;
      logic        redirect;
      logic [31:0] pc;
      logic        illegal;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'h0;
   logic [11:0] req_addr = 12'h0;
   logic [31:0] req_operand = 32'h0;
   logic [31:0] req_cause = 32'h0;
   logic [31:0] req_pc = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_redirect;
   logic [31:0] rsp_pc;
   logic        rsp_illegal;
   logic        csr_write_en;
   logic [11:0] csr_addr;
   logic [31:0] csr_din;
   logic [31:0] csr_dout;

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   string wr_log = "";
   rsp_t  exp_q[$];
   rsp_t  obs;
   rsp_t  e;

   // CSR file model
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = 12'h0;
   logic [31:0] poke_data = 32'h0;
   logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause;
   logic [11:0] wa;
   logic [31:0] wd;

   csr_ctrl #(.MIE_BIT(3), .MPIE_BIT(7)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_operand(req_operand), .req_cause(req_cause), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_redirect(rsp_redirect),
      .rsp_pc(rsp_pc), .rsp_illegal(rsp_illegal),
      .csr_write_en(csr_write_en), .csr_addr(csr_addr), .csr_din(csr_din), .csr_dout(csr_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign wa = poke_en ? poke_addr : csr_addr;
   assign wd = poke_en ? poke_data : csr_din;

   always @(posedge clk) begin
      if (poke_en || csr_write_en) begin
         case (wa)
            12'h300: m_status  <= wd;
            12'h305: m_tvec    <= wd;
            12'h340: m_scratch <= wd;
            12'h341: m_epc     <= wd;
            12'h342: m_cause   <= wd;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_dout = 32'h0;
      case (csr_addr)
         12'h300: csr_dout = m_status;
         12'h305: csr_dout = m_tvec;
         12'h340: csr_dout = m_scratch;
         12'h341: csr_dout = m_epc;
         12'h342: csr_dout = m_cause;
         12'hF14: csr_dout = 32'd5;
         default: csr_dout = 32'h0;
      endcase
   end

   // Write log, offsets counted from the acceptance cycle T
   always @(negedge clk) begin
      if (csr_write_en)
         wr_log = {wr_log, $sformatf("%h=%h@%0d ", csr_addr, csr_din, cyc - acc_cyc + 1)};
   end

   function automatic rsp_t mk(input int lat, input logic [31:0] rdata, input logic redirect,
                               input logic [31:0] pc, input logic illegal);
      rsp_t r;
      r.lat = 8'(lat);
      r.rdata = rdata;
      r.redirect = redirect;
      r.pc = pc;
      r.illegal = illegal;
      return r;
   endfunction

   function automatic string fmt(input rsp_t r);
      return $sformatf("lat=%0d rdata=%h redir=%b pc=%h ill=%b", r.lat, r.rdata, r.redirect, r.pc, r.illegal);
   endfunction

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_en = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(posedge clk);
      #1;
      poke_en = 1'b0;
   endtask

   // Drive one request, push its expected response, capture the observed one into obs
   task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] operand,
                        input logic [31:0] cause, input logic [31:0] pc, input rsp_t expv);
      bit got;
      exp_q.push_back(expv);
      wr_log = "";
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      req_operand = operand;
      req_cause = cause;
      req_pc = pc;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_before_accept got %b want 1", req_ready);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      req_op = 3'h0;
      req_operand = 32'h0;
      obs = mk(1, 32'h0, 1'b0, 32'h0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            obs.rdata = rsp_rdata;
            obs.redirect = rsp_redirect;
            obs.pc = rsp_pc;
            obs.illegal = rsp_illegal;
         end else begin
            @(posedge clk);
            obs.lat = obs.lat + 8'd1;
         end
      end
      if (!got) begin
         vectors++;
         miscompares++;
         obs.lat = 8'hFF;
         $display("FAIL rsp_timeout got no rsp_valid want one within 20 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid, rsp_redirect, rsp_illegal, csr_write_en} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 10000", {req_ready, rsp_valid, rsp_redirect, rsp_illegal, csr_write_en});
      end
      vectors++;
      if ({rsp_rdata, rsp_pc} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_rsp got %h want 0", {rsp_rdata, rsp_pc});
      end
      vectors++;
      if ({csr_addr, csr_din} !== 44'h0) begin
         miscompares++;
         $display("FAIL reset_csr got %h want 0", {csr_addr, csr_din});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL post_reset_idle got %b want 10", {req_ready, rsp_valid});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_rw();
      poke(12'h340, 32'h0);
      issue(OP_RW, 12'h340, 32'hDEADBEEF, 32'h0, 32'h0, mk(3, 32'h0, 1'b0, 32'h0, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rw_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "340=deadbeef@2 ") begin miscompares++; $display("FAIL rw_writes got '%s' want '340=deadbeef@2 '", wr_log); end
      vectors++;
      if (m_scratch !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rw_mscratch got %h want deadbeef", m_scratch); end
   endtask

   task automatic test_set_clear();
      poke(12'h340, 32'h0000F0F0);
      issue(OP_RS, 12'h340, 32'h00000F00, 32'h0, 32'h0, mk(3, 32'h0000F0F0, 1'b0, 32'h0, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rs_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "340=0000fff0@2 ") begin miscompares++; $display("FAIL rs_writes got '%s' want '340=0000fff0@2 '", wr_log); end
      issue(OP_RC, 12'h340, 32'h0000FF00, 32'h0, 32'h0, mk(3, 32'h0000FFF0, 1'b0, 32'h0, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rc_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (m_scratch !== 32'h000000F0) begin miscompares++; $display("FAIL rc_mscratch got %h want 000000f0", m_scratch); end
      issue(OP_RS, 12'h340, 32'h0, 32'h0, 32'h0, mk(3, 32'h000000F0, 1'b0, 32'h0, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rs0_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "") begin miscompares++; $display("FAIL rs0_writes got '%s' want none", wr_log); end
   endtask

   task automatic test_read_only();
      issue(OP_RW, 12'hF14, 32'h00001234, 32'h0, 32'h0, mk(3, 32'd5, 1'b0, 32'h0, 1'b1));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL ro_rw_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "") begin miscompares++; $display("FAIL ro_rw_writes got '%s' want none", wr_log); end
      issue(OP_RS, 12'hF14, 32'h0, 32'h0, 32'h0, mk(3, 32'd5, 1'b0, 32'h0, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL ro_rs0_rsp got %s want %s", fmt(obs), fmt(e)); end
      issue(OP_RC, 12'hF14, 32'h00000001, 32'h0, 32'h0, mk(3, 32'd5, 1'b0, 32'h0, 1'b1));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL ro_rc_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "") begin miscompares++; $display("FAIL ro_rc_writes got '%s' want none", wr_log); end
   endtask

   task automatic test_trap_mret();
      poke(12'h300, 32'h00001808);
      poke(12'h305, 32'h80000101);
      poke(12'h342, 32'h0);
      issue(OP_TRAP, 12'h0, 32'h0, 32'h2, 32'h00002003, mk(6, 32'h0, 1'b1, 32'h80000100, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL trap_a_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "341=00002000@1 342=00000002@2 300=00001880@4 ") begin
         miscompares++; $display("FAIL trap_a_writes got '%s' want '341=00002000@1 342=00000002@2 300=00001880@4 '", wr_log);
      end
      poke(12'h300, 32'h00000008);
      issue(OP_TRAP, 12'h0, 32'h0, 32'hB, 32'h00001002, mk(6, 32'h0, 1'b1, 32'h80000100, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL trap_b_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if ({m_epc, m_cause, m_status} !== {32'h1000, 32'hB, 32'h80}) begin
         miscompares++; $display("FAIL trap_b_state got epc=%h cause=%h st=%h want 1000/b/80", m_epc, m_cause, m_status);
      end
      issue(OP_MRET, 12'h0, 32'h0, 32'h0, 32'h0, mk(4, 32'h0, 1'b1, 32'h00001000, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL mret_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (wr_log != "300=00000088@2 ") begin miscompares++; $display("FAIL mret_writes got '%s' want '300=00000088@2 '", wr_log); end
      poke(12'h300, 32'h00000008);
      issue(OP_MRET, 12'h0, 32'h0, 32'h0, 32'h0, mk(4, 32'h0, 1'b1, 32'h00001000, 1'b0));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL mret_mpie0_rsp got %s want %s", fmt(obs), fmt(e)); end
      vectors++;
      if (m_status !== 32'h80) begin miscompares++; $display("FAIL mret_mpie0_status got %h want 00000080", m_status); end
   endtask

   task automatic test_illegal();
      logic [2:0] ops [3];
      ops = '{3'd3, 3'd6, 3'd7};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], 12'h340, 32'hFFFFFFFF, 32'h0, 32'h0, mk(1, 32'h0, 1'b0, 32'h0, 1'b1));
         e = exp_q.pop_front();
         vectors++;
         if (obs !== e) begin miscompares++; $display("FAIL illegal_op%0d_rsp got %s want %s", ops[i], fmt(obs), fmt(e)); end
         vectors++;
         if (wr_log != "") begin miscompares++; $display("FAIL illegal_op%0d_writes got '%s' want none", ops[i], wr_log); end
      end
   endtask

   // req_valid held throughout; inputs changed while busy must be ignored
   task automatic test_back_to_back();
      bit drop;
      poke(12'h340, 32'h00000011);
      exp_q.push_back(mk(3, 32'h00000011, 1'b0, 32'h0, 1'b0));
      exp_q.push_back(mk(7, 32'h000000A0, 1'b0, 32'h0, 1'b0));
      wr_log = "";
      req_valid = 1'b1;
      req_op = OP_RW;
      req_addr = 12'h340;
      req_operand = 32'h000000A0;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_op = OP_RS;
      req_operand = 32'h0000000F;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drop = (req_ready === 1'b1);
         if (rsp_valid === 1'b1) begin
            obs = mk(cyc - acc_cyc + 1, rsp_rdata, rsp_redirect, rsp_pc, rsp_illegal);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL b2b_extra_rsp got %s want none", fmt(obs));
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin miscompares++; $display("FAIL b2b_rsp got %s want %s", fmt(obs), fmt(e)); end
            end
         end
         @(posedge clk);
         #1;
         if (drop) req_valid = 1'b0;
      end
      req_op = 3'h0;
      req_operand = 32'h0;
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_missing_rsp got %0d pending want 0", exp_q.size()); exp_q.delete(); end
      vectors++;
      if (wr_log != "340=000000a0@2 340=000000af@6 ") begin
         miscompares++; $display("FAIL b2b_writes got '%s' want '340=000000a0@2 340=000000af@6 '", wr_log);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      poke(12'h300, 32'h00000008);
      poke(12'h342, 32'h00000077);
      wr_log = "";
      req_valid = 1'b1;
      req_op = OP_TRAP;
      req_cause = 32'hB;
      req_pc = 32'h00002006;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      req_op = 3'h0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (csr_write_en !== 1'b0) begin miscompares++; $display("FAIL midrst_we got %b want 0", csr_write_en); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", req_ready); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid !== 1'b0 || csr_write_en !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      vectors++;
      if (seen) begin miscompares++; $display("FAIL midrst_activity got rsp/write activity want none"); end
      vectors++;
      if (wr_log != "341=00002004@1 ") begin miscompares++; $display("FAIL midrst_writes got '%s' want '341=00002004@1 '", wr_log); end
      vectors++;
      if ({m_cause, m_status} !== {32'h77, 32'h8}) begin
         miscompares++; $display("FAIL midrst_state got cause=%h st=%h want 77/8", m_cause, m_status);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      poke(12'h300, 32'h0);
      poke(12'h305, 32'h0);
      poke(12'h340, 32'h0);
      poke(12'h341, 32'h0);
      poke(12'h342, 32'h0);
      test_reset();
      test_rw();
      test_set_clear();
      test_read_only();
      test_trap_mret();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
